// File: rtl/sram_bist_master_pkg.sv
// Shared types, bus constants and pattern helper for the SRAM BIST master.
// Also used by sram_bist_pattern, which is meant for reuse elsewhere.
package sram_bist_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_RD_REQ,
    ST_RD_CMP,
    ST_DONE
  } state_e;

  localparam logic [3:0] WSTRB_WORD = 4'hF;
  localparam logic [3:0] WSTRB_READ = 4'h0;

  function automatic logic [31:0] bist_pattern(
    input logic [15:0] idx,
    input logic        phase,
    input logic [31:0] seed
  );
    return ({idx, idx} ^ seed) ^ {32{phase}};
  endfunction

endpackage

// File: rtl/sram_bist_pattern.sv
// Combinational test-pattern generator: word index and phase to data.
// Phase 1 returns the bitwise inverse of the phase 0 pattern.
module sram_bist_pattern #(
  parameter logic [31:0] SEED = 32'hA5A5_5A5A
) (
  input  logic [15:0] idx,
  input  logic        phase,
  output logic [31:0] data
);
  import sram_bist_master_pkg::*;

  assign data = bist_pattern(idx, phase, SEED);

endmodule

// File: rtl/sram_bist_master.sv
// Two-pass write/read-verify SRAM test master on the PicoRV32 native bus.
// Each request is followed by exactly one idle gap cycle.
module sram_bist_master #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned WORDS     = 1024,
  parameter logic [31:0] SEED      = 32'hA5A5_5A5A,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,
  output logic [31:0] first_err_data,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  import sram_bist_master_pkg::*;

  localparam logic [15:0] LAST     = 16'(WORDS - 1);
  localparam logic [15:0] WAIT_MAX = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic        phase_q, phase_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        tmo_q, tmo_d;
  logic [15:0] err_q, err_d;
  logic [31:0] ferr_addr_q, ferr_addr_d;
  logic [31:0] ferr_data_q, ferr_data_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [15:0] wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] exp_q, exp_d;

  logic        last;
  logic [31:0] pat_nxt;
  logic [31:0] addr_nxt;

  assign last = (idx_q == LAST);

  // Index/phase of the next request, kept apart from the main FSM
  // so the pattern generator sees it without a combinational loop.
  always_comb begin
    idx_d   = idx_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          phase_d = 1'b0;
        end
      end
      ST_WR_GAP: idx_d = last ? '0 : idx_q + 16'd1;
      ST_RD_CMP: begin
        if (!last) begin
          idx_d = idx_q + 16'd1;
        end else if (!phase_q) begin
          idx_d   = '0;
          phase_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  sram_bist_pattern #(
    .SEED (SEED)
  ) u_pattern (
    .idx   (idx_d),
    .phase (phase_d),
    .data  (pat_nxt)
  );

  assign addr_nxt = ADDR_BASE + {14'd0, idx_d, 2'b00};

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wait_d      = wait_q;
    rdata_d     = rdata_q;
    exp_d       = exp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          tmo_d       = 1'b0;
          err_d       = '0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
          valid_d     = 1'b1;
          addr_d      = addr_nxt;
          wdata_d     = pat_nxt;
          wstrb_d     = WSTRB_WORD;
          wait_d      = '0;
          state_d     = ST_WR_REQ;
        end
      end
      ST_WR_REQ, ST_RD_REQ: begin
        if (mem_ready) begin
          valid_d = 1'b0;
          if (state_q == ST_WR_REQ) begin
            state_d = ST_WR_GAP;
          end else begin
            rdata_d = mem_rdata;
            state_d = ST_RD_CMP;
          end
        end else if (wait_q == WAIT_MAX) begin
          valid_d = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_WR_GAP: begin
        valid_d = 1'b1;
        addr_d  = addr_nxt;
        wait_d  = '0;
        if (last) begin
          wdata_d = '0;
          wstrb_d = WSTRB_READ;
          exp_d   = pat_nxt;
          state_d = ST_RD_REQ;
        end else begin
          wdata_d = pat_nxt;
          wstrb_d = WSTRB_WORD;
          state_d = ST_WR_REQ;
        end
      end
      ST_RD_CMP: begin
        if (rdata_q != exp_q) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == 16'd0) begin
            ferr_addr_d = addr_q;
            ferr_data_d = rdata_q;
          end
        end
        if (!last) begin
          valid_d = 1'b1;
          addr_d  = addr_nxt;
          wdata_d = '0;
          wstrb_d = WSTRB_READ;
          exp_d   = pat_nxt;
          wait_d  = '0;
          state_d = ST_RD_REQ;
        end else if (!phase_q) begin
          valid_d = 1'b1;
          addr_d  = addr_nxt;
          wdata_d = pat_nxt;
          wstrb_d = WSTRB_WORD;
          wait_d  = '0;
          state_d = ST_WR_REQ;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == 16'd0) && !tmo_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      tmo_q       <= 1'b0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wait_q      <= '0;
      rdata_q     <= '0;
      exp_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
      exp_q       <= exp_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = tmo_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;
  assign mem_valid      = valid_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wstrb      = wstrb_q;

endmodule

// File: tb/tb_sram_bist_master.sv
// Directed bench for sram_bist_master: memory models, bus protocol
// monitors and a linear sequence of checked scenarios.
module tb_sram_bist_master;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic start16 = 1'b0;
  always #5 clk = ~clk;

  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] fe_addr, fe_data;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  sram_bist_master #(
    .ADDR_BASE (32'h0000_0000),
    .WORDS     (4),
    .SEED      (32'hA5A5_5A5A),
    .TIMEOUT   (255)
  ) u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (fe_addr),
    .first_err_data (fe_data),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata)
  );

  logic        b16, d16, p16, to16, v16, r16;
  logic [15:0] ec16;
  logic [31:0] fa16, fd16, a16, wd16, rd16;
  logic [3:0]  ws16;

  sram_bist_master #(
    .ADDR_BASE (32'h0000_0100),
    .WORDS     (16),
    .SEED      (32'hA5A5_5A5A),
    .TIMEOUT   (255)
  ) u_dut16 (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start16),
    .busy           (b16),
    .done           (d16),
    .pass           (p16),
    .timeout        (to16),
    .err_count      (ec16),
    .first_err_addr (fa16),
    .first_err_data (fd16),
    .mem_valid      (v16),
    .mem_addr       (a16),
    .mem_wdata      (wd16),
    .mem_wstrb      (ws16),
    .mem_ready      (r16),
    .mem_rdata      (rd16)
  );

  // Memory model for the 4-word instance: latency, bit-flip, no-reply.
  logic        rdy = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] rdat = '0;
  logic [31:0] mem_a [4];
  int          lat = 3;
  int          cnt = 0;
  bit          flip = 1'b0;
  bit          never = 1'b0;

  assign mem_ready = rdy | stray;
  assign mem_rdata = rdat;

  always @(posedge clk) begin
    rdy <= 1'b0;
    if (!mem_valid) begin
      cnt <= 0;
    end else if (!rdy && !never) begin
      if (cnt == lat - 1) begin
        rdy <= 1'b1;
        cnt <= 0;
        if (mem_wstrb == 4'hF)
          mem_a[mem_addr[3:2]] <= mem_wdata;
        else
          rdat <= mem_a[mem_addr[3:2]]
                  ^ ((flip && mem_addr == 32'h8) ? 32'd1 : 32'd0);
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  // Memory model for the 16-word instance: one-cycle latency.
  logic [31:0] m16 [16];
  logic [31:0] rd16_q = '0;
  logic        r16_q = 1'b0;
  assign r16  = r16_q;
  assign rd16 = rd16_q;

  always @(posedge clk) begin
    r16_q <= 1'b0;
    if (v16 && !r16_q) begin
      r16_q <= 1'b1;
      if (ws16 == 4'hF) m16[a16[5:2]] <= wd16;
      else rd16_q <= m16[a16[5:2]];
    end
  end

  // Protocol monitor, 4-word instance.
  logic        pv = 1'b0, pr = 1'b0, pb = 1'b0;
  logic [67:0] pbus = '0;
  logic [67:0] tlog [64];
  int          gap = 0, hi = 0, last_hi = 0;
  int          txn = 0, proto_err = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      pv  <= 1'b0;
      pr  <= 1'b0;
      pb  <= 1'b0;
      gap <= 0;
      hi  <= 0;
    end else begin
      proto_err <= proto_err
        + int'(pv && pr && mem_valid)
        + int'(pv && !pr && mem_valid &&
               {mem_addr, mem_wdata, mem_wstrb} != pbus)
        + int'(mem_valid && !pv && pb && gap != 1);
      pv   <= mem_valid;
      pr   <= mem_ready;
      pb   <= busy;
      pbus <= {mem_addr, mem_wdata, mem_wstrb};
      gap  <= mem_valid ? 0 : gap + 1;
      hi   <= mem_valid ? hi + 1 : 0;
      if (pv && !mem_valid) last_hi <= hi;
      if (mem_valid && mem_ready) begin
        tlog[txn % 64] <= {mem_addr, mem_wdata, mem_wstrb};
        txn <= txn + 1;
      end
    end
  end

  // Protocol monitor, 16-word instance.
  logic        pv16 = 1'b0, pr16 = 1'b0, pb16 = 1'b0;
  logic [67:0] pbus16 = '0;
  int          gap16 = 0, txn16 = 0, proto16 = 0;
  logic [31:0] last_a16 = '0;

  always @(posedge clk) begin
    if (!resetn) begin
      pv16  <= 1'b0;
      pr16  <= 1'b0;
      pb16  <= 1'b0;
      gap16 <= 0;
    end else begin
      proto16 <= proto16
        + int'(pv16 && pr16 && v16)
        + int'(pv16 && !pr16 && v16 && {a16, wd16, ws16} != pbus16)
        + int'(v16 && !pv16 && pb16 && gap16 != 1);
      pv16   <= v16;
      pr16   <= r16;
      pb16   <= b16;
      pbus16 <= {a16, wd16, ws16};
      gap16  <= v16 ? 0 : gap16 + 1;
      if (v16 && r16) begin
        txn16    <= txn16 + 1;
        last_a16 <= a16;
      end
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input bit which);
    @(negedge clk);
    if (which) start16 = 1'b1;
    else start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int budget);
    int n = 0;
    while (!(which ? d16 : done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_budget", 32'(which ? d16 : done), 32'd1);
  endtask

  logic [31:0] pat [4];
  logic [67:0] e;
  int          t0, n;

  initial begin
    pat[0] = 32'hA5A5_5A5A;
    pat[1] = 32'hA5A4_5A5B;
    pat[2] = 32'hA5A7_5A58;
    pat[3] = 32'hA5A6_5A59;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_fe_addr", fe_addr, 32'd0);
    chk("rst_fe_data", fe_data, 32'd0);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run, 3-cycle memory.
    t0 = txn;
    pulse(1'b0);
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    chk("t1_valid_after_start", 32'(mem_valid), 32'd1);
    chk("t1_first_wdata", mem_wdata, pat[0]);
    wait_done(1'b0, 2000);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_err", 32'(err_count), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_timeout", 32'(timeout), 32'd0);
    chk("t1_txns", 32'(txn - t0), 32'd16);
    chk("t1_proto", 32'(proto_err), 32'd0);
    for (int k = 0; k < 4; k++) begin
      e = tlog[(t0 + k) % 64];
      chk("t1_wr_addr", e[67:36], 32'(4 * k));
      chk("t1_wr_data", e[35:4], pat[k]);
      chk("t1_wr_strb", 32'(e[3:0]), 32'hF);
      e = tlog[(t0 + 4 + k) % 64];
      chk("t1_rd_addr", e[67:36], 32'(4 * k));
      chk("t1_rd_strb", 32'(e[3:0]), 32'h0);
      e = tlog[(t0 + 8 + k) % 64];
      chk("t1_wr1_addr", e[67:36], 32'(4 * k));
      chk("t1_wr1_data", e[35:4], ~pat[k]);
      e = tlog[(t0 + 12 + k) % 64];
      chk("t1_rd1_strb", 32'(e[3:0]), 32'h0);
    end

    // Bit 0 flipped on reads of 0x8 in both passes.
    flip = 1'b1;
    pulse(1'b0);
    wait_done(1'b0, 2000);
    chk("t2_err", 32'(err_count), 32'd2);
    chk("t2_fe_addr", fe_addr, 32'h8);
    chk("t2_fe_data", fe_data, 32'hA5A7_5A59);
    chk("t2_pass", 32'(pass), 32'd0);
    flip = 1'b0;

    // Memory never answers.
    never = 1'b1;
    pulse(1'b0);
    wait_done(1'b0, 1000);
    chk("t3_timeout", 32'(timeout), 32'd1);
    chk("t3_pass", 32'(pass), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_valid", 32'(mem_valid), 32'd0);
    chk("t3_valid_len", 32'(last_hi), 32'd255);
    chk("t3_err", 32'(err_count), 32'd0);
    never = 1'b0;

    // Second start while busy, stray ready in every gap cycle.
    t0 = txn;
    pulse(1'b0);
    repeat (5) @(negedge clk);
    pulse(1'b0);
    n = 0;
    while (!done && n < 2000) begin
      stray = busy && !mem_valid;
      @(negedge clk);
      n++;
    end
    stray = 1'b0;
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_pass", 32'(pass), 32'd1);
    chk("t4_err", 32'(err_count), 32'd0);
    chk("t4_timeout", 32'(timeout), 32'd0);
    chk("t4_fe_addr", fe_addr, 32'd0);
    chk("t4_txns", 32'(txn - t0), 32'd16);
    repeat (10) @(negedge clk);
    chk("t4_no_restart", 32'(busy), 32'd0);
    chk("t4_txns_after", 32'(txn - t0), 32'd16);
    chk("t4_proto", 32'(proto_err), 32'd0);

    // Async reset during a pass-0 read request.
    pulse(1'b0);
    n = 0;
    while (!(mem_valid && mem_wstrb == 4'h0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rd_req_seen", 32'(mem_valid && mem_wstrb == 4'h0), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(mem_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_addr", mem_addr, 32'd0);
    chk("t5_rst_err", 32'(err_count), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    pulse(1'b0);
    wait_done(1'b0, 2000);
    chk("t5_pass", 32'(pass), 32'd1);
    chk("t5_err", 32'(err_count), 32'd0);

    // 16-word instance, base 0x100.
    pulse(1'b1);
    wait_done(1'b1, 2000);
    chk("t6_pass", 32'(p16), 32'd1);
    chk("t6_err", 32'(ec16), 32'd0);
    chk("t6_txns", 32'(txn16), 32'd64);
    chk("t6_last_addr", last_a16, 32'h13C);
    chk("t6_proto", 32'(proto16), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
